universal_shift_register: RTL and testbench

UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

---
 rtl/universal_shift_register.sv | 103 ++++++++++
 tb/tb_universal_shift_register.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/universal_shift_register.sv
// universal_shift_register
//   Width-configurable shift register with hold, shift right, shift left and
//   parallel load.
//   Shifts either take serial data in or rotate, depending on ROTATE.
//   A saturating counter counts the shifts made since the last load or reset.
//   done goes high when that counter reaches WIDTH.
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous reset, active-low
//   en      update enable; low holds all state
//   mode    00 hold, 01 shift right, 10 shift left, 11 parallel load
//   d       parallel load data
//   sin_r   serial bit entering the MSB on a right shift (ignored when rotating)
//   sin_l   serial bit entering the LSB on a left shift (ignored when rotating)
//   q       register contents
//   qb      ~q
//   sout_r  q[0], the bit the next right shift drops
//   sout_l  q[WIDTH-1], the bit the next left shift drops
//   cnt     shifts since last load/reset, saturates at WIDTH
//   done    sticky flag, set on the edge where cnt reaches WIDTH
module universal_shift_register #(
   parameter int  WIDTH  = 8,
   parameter int  ROTATE = 0,
   localparam int CW     = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin_r,
   input  logic             sin_l,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb,
   output logic             sout_r,
   output logic             sout_l,
   output logic [CW-1:0]    cnt,
   output logic             done
);

   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_SHR  = 2'b01,
      MODE_SHL  = 2'b10,
      MODE_LOAD = 2'b11
   } mode_t;

   localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

   mode_t         mode_sel;
   logic          shr_in;
   logic          shl_in;
   logic [CW-1:0] cnt_sat;
   logic          done_sat;

   always_comb begin
      mode_sel = mode_t'(mode);
      // When rotating, the bit shifted out is fed back in at the other end.
      shr_in   = (ROTATE != 0) ? q[0]       : sin_r;
      shl_in   = (ROTATE != 0) ? q[WIDTH-1] : sin_l;
      // Counter value after one more shift: stops at WIDTH instead of wrapping.
      cnt_sat  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
      // done follows cnt on the same edge, so it never lags by a cycle.
      done_sat = (cnt_sat == CNT_MAX);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         q    <= '0;
         cnt  <= '0;
         done <= 1'b0;
      end else if (en) begin
         case (mode_sel)
            MODE_SHR: begin
               q    <= {shr_in, q[WIDTH-1:1]};
               cnt  <= cnt_sat;
               done <= done_sat;
            end
            MODE_SHL: begin
               q    <= {q[WIDTH-2:0], shl_in};
               cnt  <= cnt_sat;
               done <= done_sat;
            end
            MODE_LOAD: begin
               q    <= d;
               cnt  <= '0;
               done <= 1'b0;
            end
            default: begin
               q    <= q;
               cnt  <= cnt;
               done <= done;
            end
         endcase
      end
   end

   assign qb     = ~q;
   assign sout_r = q[0];
   assign sout_l = q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_register.sv
module tb_universal_shift_register;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [1:0] mode;
   logic [7:0] d;
   logic       sin_r;
   logic       sin_l;

   logic [7:0] q, qb;
   logic       sout_r, sout_l;
   logic [3:0] cnt;
   logic       done;

   logic [7:0] r_q, r_qb;
   logic       r_sout_r, r_sout_l;
   logic [3:0] r_cnt;
   logic       r_done;

   int n_chk  = 0;
   int n_pass = 0;

   universal_shift_register #(.WIDTH(8), .ROTATE(0)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
      .sin_r(sin_r), .sin_l(sin_l),
      .q(q), .qb(qb), .sout_r(sout_r), .sout_l(sout_l),
      .cnt(cnt), .done(done)
   );

   universal_shift_register #(.WIDTH(8), .ROTATE(1)) dut_rot (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
      .sin_r(sin_r), .sin_l(sin_l),
      .q(r_q), .qb(r_qb), .sout_r(r_sout_r), .sout_l(r_sout_l),
      .cnt(r_cnt), .done(r_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [7:0] val);
      en   = 1'b1;
      mode = 2'b11;
      d    = val;
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset wins over a load presented on the same edge
      rst = 1'b0; en = 1'b1; mode = 2'b11; d = 8'hA5; sin_r = 1'b0; sin_l = 1'b0;
      step();
      chk("rst_q",      q,      8'h00);
      chk("rst_qb",     qb,     8'hFF);
      chk("rst_cnt",    cnt,    0);
      chk("rst_done",   done,   0);
      chk("rst_sout_r", sout_r, 0);
      chk("rst_sout_l", sout_l, 0);

      // Load then shift right; sout_r shows the outgoing bit before the edge
      rst = 1'b1;
      load(8'hA5);
      chk("load_a5", q, 8'hA5);
      mode = 2'b01; sin_r = 1'b0;
      #1;
      chk("shr_sout_r_pre", sout_r, 1);
      chk("shr_sout_l_pre", sout_l, 1);
      step();
      chk("shr_q",   q,   8'h52);
      chk("shr_cnt", cnt, 1);

      // Shift-left saturation run
      load(8'h81);
      mode = 2'b10; sin_l = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         step();
         if (i == 7) begin
            chk("shl7_q",    q,    8'hFF);
            chk("shl7_cnt",  cnt,  7);
            chk("shl7_done", done, 0);
         end
         if (i == 8) begin
            chk("shl8_q",    q,    8'hFF);
            chk("shl8_cnt",  cnt,  8);
            chk("shl8_done", done, 1);
         end
         if (i == 9) begin
            chk("shl9_cnt",  cnt,  8);
            chk("shl9_done", done, 1);
         end
      end

      // Load clears done/cnt; en=0 freezes; mode 00 holds
      load(8'h3C);
      chk("reload_done", done, 0);
      chk("reload_cnt",  cnt,  0);
      en = 1'b0; mode = 2'b01; sin_r = 1'b1;
      repeat (3) step();
      chk("en0_q",   q,   8'h3C);
      chk("en0_cnt", cnt, 0);
      en = 1'b1; mode = 2'b00;
      step();
      chk("hold_q",   q,   8'h3C);
      chk("hold_cnt", cnt, 0);

      // Mixed directions, back-to-back mode changes, both counted
      mode = 2'b01; sin_r = 1'b1;
      step();
      chk("mix_r_q", q, 8'h9E);
      mode = 2'b10; sin_l = 1'b0;
      step();
      chk("mix_l_q",   q,   8'h3C);
      chk("mix_l_cnt", cnt, 2);

      // Rotating instance: sin_r toggles but must not matter
      load(8'h01);
      mode = 2'b01;
      for (int i = 1; i <= 8; i++) begin
         sin_r = i[0];
         step();
         if (i == 1) chk("rot1_q", r_q, 8'h80);
      end
      chk("rot8_q",    r_q,    8'h01);
      chk("rot8_cnt",  r_cnt,  8);
      chk("rot8_done", r_done, 1);
      mode = 2'b10; sin_l = 1'b0;
      step();
      chk("rotl_q", r_q, 8'h02);

      // Reset colliding with a load mid-sequence
      load(8'hF0);
      mode = 2'b10; sin_l = 1'b0;
      repeat (4) step();
      chk("coll_pre_cnt", cnt, 4);
      chk("coll_pre_q",   q,   8'h00);
      rst = 1'b0; mode = 2'b11; d = 8'h55;
      step();
      chk("coll_q",    q,    8'h00);
      chk("coll_cnt",  cnt,  0);
      chk("coll_done", done, 0);
      rst = 1'b1;
      load(8'h55);
      chk("coll_reload_q", q, 8'h55);

      // Reset is synchronous: no effect until the edge, and it beats en=0
      rst = 1'b0; en = 1'b0;
      #2;
      chk("rst_sync_q", q, 8'h55);
      step();
      chk("rst_en0_q", q, 8'h00);
      rst = 1'b1; en = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
